// File: rtl/generator_fifo_wrapper.sv
// generator_fifo_wrapper
//   AXI4-Stream master traffic source. While enabled, an internal generator
//   writes the sequence 1,2,3,... (tagged with a last flag every PACKET_LEN
//   beats) into a small synchronous FIFO. A single-slot registered output
//   stage drains the FIFO toward the downstream slave, honouring tready.
//
// Ports
//   m00_axis_aclk     in   clock, rising edge
//   m00_axis_aresetn  in   synchronous reset, active HIGH (name kept as-is)
//   m00_axis_enable   in   generator run enable (level)
//   m00_axis_tdata    out  stream data
//   m00_axis_tstrb    out  byte strobes, all ones while tvalid
//   m00_axis_tvalid   out  beat valid
//   m00_axis_tlast    out  last beat of packet (qualified by tvalid)
//   m00_axis_tready   in   downstream ready
module generator_fifo_wrapper #(
  parameter int DATA_SIZE  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int PACKET_LEN = 8
) (
  input  logic                   m00_axis_aclk,
  input  logic                   m00_axis_aresetn,
  input  logic                   m00_axis_enable,
  output logic [DATA_SIZE-1:0]   m00_axis_tdata,
  output logic [DATA_SIZE/8-1:0] m00_axis_tstrb,
  output logic                   m00_axis_tvalid,
  output logic                   m00_axis_tlast,
  input  logic                   m00_axis_tready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam int EW = DATA_SIZE + 1;

  logic clk;
  logic srst;
  assign clk  = m00_axis_aclk;
  assign srst = m00_axis_aresetn;  // despite the name, 1 means reset

  // Generator state
  logic [DATA_SIZE-1:0] value_reg, value_next;
  logic [BW-1:0]        beat_reg, beat_next;

  // FIFO state
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  // Output slot
  logic [DATA_SIZE-1:0] tdata_reg;
  logic                 tlast_reg;
  logic                 tvalid_reg;

  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  logic          last_flag;
  logic [EW-1:0] rd_entry;

  always_comb begin
    full      = (count_reg == CW'(FIFO_DEPTH));
    empty     = (count_reg == '0);
    wr_en     = m00_axis_enable && !full;
    // Slot can take a new word when it is empty or being emptied this edge.
    rd_en     = !empty && (!tvalid_reg || m00_axis_tready);
    last_flag = (beat_reg == BW'(PACKET_LEN - 1));
    rd_entry  = mem[rd_ptr_reg];

    value_next  = value_reg;
    beat_next   = beat_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;

    if (wr_en) begin
      value_next  = value_reg + 1'b1;
      beat_next   = last_flag ? '0 : beat_reg + 1'b1;
      wr_ptr_next = wr_ptr_reg + 1'b1;  // power-of-two depth wraps naturally
    end
    if (rd_en) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      value_reg  <= DATA_SIZE'(1);
      beat_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      value_reg  <= value_next;
      beat_reg   <= beat_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage array has no reset so it maps onto RAM; the output slot below
  // acts as its registered read port.
  always_ff @(posedge clk) begin
    if (wr_en && !srst) begin
      mem[wr_ptr_reg] <= {last_flag, value_reg};
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      tdata_reg  <= '0;
      tlast_reg  <= 1'b0;
      tvalid_reg <= 1'b0;
    end else if (rd_en) begin
      tlast_reg  <= rd_entry[EW-1];
      tdata_reg  <= rd_entry[DATA_SIZE-1:0];
      tvalid_reg <= 1'b1;
    end else if (tvalid_reg && m00_axis_tready) begin
      // Accepted with nothing behind it: slot goes idle.
      tdata_reg  <= '0;
      tlast_reg  <= 1'b0;
      tvalid_reg <= 1'b0;
    end
  end

  assign m00_axis_tdata  = tdata_reg;
  assign m00_axis_tvalid = tvalid_reg;
  assign m00_axis_tlast  = tlast_reg && tvalid_reg;

  for (genvar gi = 0; gi < DATA_SIZE / 8; gi++) begin : g_strb
    assign m00_axis_tstrb[gi] = tvalid_reg;
  end

endmodule

// File: tb/tb_generator_fifo_wrapper.sv
// Directed bench for generator_fifo_wrapper (32-bit data, depth 16, packets of 8).
module tb_generator_fifo_wrapper;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tvalid;
  logic        tlast;

  int checks;
  int errors;
  int unsigned exp_val;
  int accepted;
  int base_acc;

  generator_fifo_wrapper #(
    .DATA_SIZE (32),
    .FIFO_DEPTH(16),
    .PACKET_LEN(8)
  ) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_aresetn(rst),
    .m00_axis_enable (en),
    .m00_axis_tdata  (tdata),
    .m00_axis_tstrb  (tstrb),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tlast  (tlast),
    .m00_axis_tready (rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: score any handshake taking place on the coming edge, then
  // confirm a stalled beat is held stable across it.
  task automatic cycle();
    logic        hold;
    logic [31:0] held;
    hold = (tvalid === 1'b1) && (rdy === 1'b0) && (rst === 1'b0);
    held = tdata;
    if (tvalid === 1'b1 && rdy === 1'b1 && rst === 1'b0) begin
      check("beat_data", tdata, exp_val);
      check("beat_last", tlast, (exp_val % 8) == 0);
      check("beat_strb", tstrb, 4'hF);
      $display("beat data=%0d last=%0b", tdata, tlast);
      exp_val++;
      accepted++;
    end
    @(posedge clk);
    #1;
    if (hold) begin
      check("hold_valid", tvalid, 1'b1);
      check("hold_data", tdata, held);
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_val = 1; accepted = 0;
    rst = 1'b1; en = 1'b0; rdy = 1'b0;
    @(posedge clk); #1;

    // Reset then idle
    repeat (3) cycle();
    check("rst_valid", tvalid, 1'b0);
    check("rst_last", tlast, 1'b0);
    check("rst_strb", tstrb, 4'h0);
    check("rst_data", tdata, 32'h0);
    rst = 1'b0;
    repeat (10) cycle();
    check("idle_valid", tvalid, 1'b0);
    check("idle_strb", tstrb, 4'h0);

    // Free run: valid two edges after enable is sampled, then 1 beat/cycle
    en = 1'b1; rdy = 1'b1;
    cycle();
    check("lat_n_valid", tvalid, 1'b0);
    cycle();
    check("lat_n1_valid", tvalid, 1'b1);
    check("lat_n1_data", tdata, 32'd1);
    repeat (20) cycle();
    check("free_count", accepted, 20);
    check("free_next", exp_val, 21);

    // Reset while stalled with a partly full FIFO
    rdy = 1'b0;
    repeat (5) cycle();
    check("pre_rst_valid", tvalid, 1'b1);
    rst = 1'b1;
    cycle();
    check("midrst_valid", tvalid, 1'b0);
    check("midrst_data", tdata, 32'h0);
    check("midrst_last", tlast, 1'b0);
    en = 1'b0;
    cycle();
    rst = 1'b0;
    exp_val = 1; accepted = 0;

    // Back-pressure fill: 17 words buffered, then drain
    en = 1'b1; rdy = 1'b0;
    repeat (40) cycle();
    check("bp_valid", tvalid, 1'b1);
    check("bp_data", tdata, 32'd1);
    en = 1'b0; rdy = 1'b1;
    repeat (25) cycle();
    check("bp_count", accepted, 17);
    check("bp_empty", tvalid, 1'b0);
    en = 1'b1;
    repeat (10) cycle();
    en = 1'b0;
    repeat (5) cycle();
    check("bp_resume", exp_val, 28);

    // Enable pulse of two edges
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    exp_val = 1; accepted = 0;
    en = 1'b1; rdy = 1'b1;
    repeat (2) cycle();
    en = 1'b0; rdy = 1'b0;
    repeat (3) cycle();
    rdy = 1'b1;
    repeat (5) cycle();
    check("pulse_count", accepted, 2);
    check("pulse_next", exp_val, 3);
    check("pulse_idle", tvalid, 1'b0);
    en = 1'b1;
    repeat (12) cycle();
    check("pulse_resume", exp_val, 13);

    // Random tready with the generator running
    base_acc = accepted;
    for (int i = 0; i < 200; i++) begin
      rdy = 1'($urandom_range(0, 1));
      cycle();
    end
    en = 1'b0; rdy = 1'b1;
    repeat (25) cycle();
    check("rand_drained", tvalid, 1'b0);
    check("rand_progress", (accepted - base_acc) >= 30, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/generator_fifo_wrapper.md
Name: generator_fifo_wrapper

Overview:
- Self-contained AXI4-Stream master test source.
- An internal generator produces an incrementing data word sequence while enabled and pushes it into an internal synchronous FIFO.
- A registered AXI-Stream output stage drains the FIFO toward a downstream slave, with back-pressure via tready.
- Used as a stimulus/traffic source in front of stream consumers.

Parameters:
- DATA_SIZE, 32, tdata width in bits; must be a multiple of 8.
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.
- PACKET_LEN, 8, beats per packet; tlast marks the final beat.

Ports:
- m00_axis_aclk  input  1  sole clock; all logic on rising edge.
- m00_axis_aresetn  input  1  reset. One clock; reset is synchronous and active-high: asserted when this port is 1. The name is kept for codebase consistency.
- m00_axis_enable  input  1  generator run enable, level-sensitive.
- m00_axis_tdata  output  DATA_SIZE  stream data.
- m00_axis_tstrb  output  DATA_SIZE/8  byte strobes.
- m00_axis_tvalid  output  1  output beat valid.
- m00_axis_tlast  output  1  last beat of packet.
- m00_axis_tready  input  1  downstream ready.

Behaviour:
- Reset (sampled 1 on a rising edge) clears the following; it overrides all other activity, including mid-packet and mid-handshake:
  - generator value register → 1
  - beat counter → 0
  - FIFO pointers and count → 0
  - output register
- Outputs during and after reset: tvalid=0, tlast=0, tdata=0, tstrb=0.
- Inputs may be X before the first reset. Outputs are defined only after reset has been sampled.
- Generator:
  - On each edge with reset=0, enable=1 and FIFO not full, write {last, value} into the FIFO.
  - last=1 when the beat counter equals PACKET_LEN-1.
  - After a write: value increments by 1, wrapping modulo 2^DATA_SIZE; beat counter increments, wrapping to 0 after PACKET_LEN-1.
  - enable=0 or FIFO full: no write, counters hold. Sequence and packet position resume exactly where they stopped.
- FIFO:
  - Stores DATA_SIZE+1 bits per entry: data plus last.
  - full when count==FIFO_DEPTH; empty when count==0.
  - A write is refused when full, even if a read occurs in the same cycle.
  - Simultaneous read and write: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Output stage, one register slot:
  - Loads from the FIFO when FIFO not empty AND (tvalid==0 OR tready==1).
  - If the slot is vacated by a handshake and the FIFO is empty, tvalid goes 0 on that edge.
  - tvalid, tdata and tlast change only at a handshake (tvalid&&tready) or on a load into an empty slot. Once tvalid=1, data is held stable until accepted (AXI rule).
  - tstrb = all ones whenever tvalid=1; 0 otherwise.
  - tlast is valid only with tvalid; driven 0 when tvalid=0.
- Latency:
  - enable sampled 1 at edge N with an empty pipeline → word written at N.
  - Output register loaded at N+1 → tvalid=1 after edge N+1.
- Throughput: one beat per cycle sustained with enable=1 and tready=1.
- tready=0 with enable=1:
  - Output holds the first word.
  - FIFO fills to FIFO_DEPTH (FIFO_DEPTH+1 words buffered in total), then generation stalls.
  - No word is ever dropped or duplicated.
- Accepted sequence across any stall, enable toggling or back-pressure is always 1,2,3,… with tlast on every PACKET_LEN-th beat (values that are multiples of PACKET_LEN).

Test Plan:
- Reset then idle: reset=1 for 3 edges, then 0, enable=0, tready=0 → tvalid=0, tlast=0, tstrb=0 indefinitely.
- Free run: enable=1, tready=1 → tvalid rises 2 edges after enable is sampled; accepted tdata 1,2,3,… one per cycle; tlast=1 on beats with data 8 and 16; tstrb=4'hF.
- Back-pressure fill: enable=1, tready=0 for 40 cycles → tdata held at 1 with tvalid=1; generator stalls after 17 words. Then tready=1 → exactly 1..17 delivered in order, then generation continues from 18.
- Enable pulse: enable=1 for 2 edges (values 1,2) then 0; tready high then low mid-stream → exactly 2 beats (1,2) delivered, no tlast; later enable=1 resumes at 3 with tlast at 8.
- Random tready toggling with enable=1 for 200 cycles → scoreboard sees a strictly consecutive sequence, tlast exactly on multiples of 8, and tdata stable while tvalid=1 and tready=0.
- Reset mid-operation with FIFO partially full and tvalid=1 → next cycle tvalid=0; after release the sequence restarts at 1 with the packet counter at 0.
